// File: rtl/result_streamer.sv
// Frame serialiser: latches N_WORDS result words plus a mode code on start, then streams header,
// MSB-first payload and (with RESULT_STREAMER_CHECKSUM_EN defined) an XOR checksum byte.
module result_streamer #(
  parameter int WORD_W      = 32,
  parameter int N_WORDS     = 2,
  parameter int MODE_W      = 3,
  parameter int BYTE_CYCLES = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [MODE_W-1:0]           mode,
  input  logic [N_WORDS*WORD_W-1:0]   words,
  output logic                        busy,
  output logic                        out_valid,
  output logic [7:0]                  out_byte,
  output logic                        done
);

  localparam int BPW    = WORD_W / 8;
  localparam int BIDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int WIDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

  localparam logic [7:0]        HOLD_LAST = 8'(BYTE_CYCLES - 1);
  localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(BPW - 1);
  localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(N_WORDS - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HEADER  = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_CHECK   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  // State entered once the last payload byte (or a mode-0 header) has been held.
`ifdef RESULT_STREAMER_CHECKSUM_EN
  localparam logic [2:0] S_TAIL = S_CHECK;
`else
  localparam logic [2:0] S_TAIL = S_DONE;
`endif

  logic [2:0]                  state_q, state_d;
  logic [7:0]                  hold_q, hold_d;
  logic [BIDX_W-1:0]           bidx_q, bidx_d;
  logic [WIDX_W-1:0]           widx_q, widx_d;
  logic [MODE_W-1:0]           mode_q, mode_d;
  logic [N_WORDS*WORD_W-1:0]   shadow_q, shadow_d;
  logic [7:0]                  out_byte_q, out_byte_d;
  logic                        out_valid_q, out_valid_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        last_hold;
  logic [7:0]                  pl_byte;
`ifdef RESULT_STREAMER_CHECKSUM_EN
  logic [7:0]                  csum_q, csum_d;
`endif

  assign last_hold = (hold_q == HOLD_LAST);

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    bidx_d   = bidx_q;
    widx_d   = widx_q;
    mode_d   = mode_q;
    shadow_d = shadow_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          state_d  = S_HEADER;
          mode_d   = mode;
          shadow_d = words;
          hold_d   = '0;
          bidx_d   = '0;
          widx_d   = '0;
        end
      end
      S_HEADER: begin
        if (last_hold) begin
          hold_d  = '0;
          bidx_d  = '0;
          widx_d  = '0;
          state_d = (mode_q == '0) ? S_TAIL : S_PAYLOAD;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      S_PAYLOAD: begin
        if (last_hold) begin
          hold_d = '0;
          if (bidx_q == BIDX_LAST) begin
            bidx_d = '0;
            if (widx_q == WIDX_LAST) state_d = S_TAIL;
            else                     widx_d  = widx_q + 1'b1;
          end else begin
            bidx_d = bidx_q + 1'b1;
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
`ifdef RESULT_STREAMER_CHECKSUM_EN
      S_CHECK: begin
        if (last_hold) begin
          hold_d  = '0;
          state_d = S_DONE;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Payload byte selected by the upcoming word/byte indices; byte 0 of a word is its MSB.
  always_comb begin
    pl_byte = '0;
    for (int w = 0; w < N_WORDS; w++) begin
      for (int b = 0; b < BPW; b++) begin
        if (widx_d == WIDX_W'(w) && bidx_d == BIDX_W'(b))
          pl_byte = shadow_q[w*WORD_W + (BPW-1-b)*8 +: 8];
      end
    end
  end

  always_comb begin
    out_byte_d  = '0;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    case (state_d)
      S_HEADER: begin
        out_byte_d  = 8'hA0 | 8'(mode_d);
        out_valid_d = 1'b1;
        busy_d      = 1'b1;
      end
      S_PAYLOAD: begin
        out_byte_d  = pl_byte;
        out_valid_d = 1'b1;
        busy_d      = 1'b1;
      end
`ifdef RESULT_STREAMER_CHECKSUM_EN
      S_CHECK: begin
        out_byte_d  = csum_q;
        out_valid_d = 1'b1;
        busy_d      = 1'b1;
      end
`endif
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

`ifdef RESULT_STREAMER_CHECKSUM_EN
  // Accumulate each header/payload byte at the edge where it is first presented.
  always_comb begin
    csum_d = csum_q;
    if (state_d == S_HEADER && state_q != S_HEADER)
      csum_d = out_byte_d;
    else if (state_d == S_PAYLOAD && (state_q != S_PAYLOAD || last_hold))
      csum_d = csum_q ^ out_byte_d;
  end

  always_ff @(posedge clk) begin
    if (rst) csum_q <= '0;
    else     csum_q <= csum_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      bidx_q      <= '0;
      widx_q      <= '0;
      mode_q      <= '0;
      shadow_q    <= '0;
      out_byte_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      bidx_q      <= bidx_d;
      widx_q      <= widx_d;
      mode_q      <= mode_d;
      shadow_q    <= shadow_d;
      out_byte_q  <= out_byte_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_byte  = out_byte_q;
  assign done      = done_q;

endmodule
